// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: shadows a 32-bit word on load and
// scans it out one hex digit at a time with registered active-low outputs.
module seg7_scan_driver #(
   parameter int CLK_DIV = 50000,
   parameter int DIGITS  = 8,
   parameter bit LZS     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic        load,
   input  logic [7:0]  blank_mask,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [2:0]  digit_idx
);

   localparam int            DW       = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

   logic [31:0]   shadow;
   logic [DW-1:0] div_cnt;
   logic [7:0]    lz_blank;
   logic [3:0]    nib;
   logic [6:0]    seg_nxt;
   logic [7:0]    an_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else if (load) begin
         shadow <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         digit_idx <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt   <= '0;
         digit_idx <= (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // Walk from the top digit down so each digit sees "everything at or above me is zero".
   always_comb begin
      logic zero_above;
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int k = 7; k >= 0; k--) begin
         if (k < DIGITS) begin
            zero_above = zero_above & (shadow[4*k +: 4] == 4'h0);
            if (LZS && (k > 0)) begin
               lz_blank[k] = zero_above;
            end
         end
      end
   end

   assign nib     = shadow[{digit_idx, 2'b00} +: 4];
   assign seg_nxt = (blank_mask[digit_idx] | lz_blank[digit_idx]) ? 7'h7F : hex7(nib);
   assign an_nxt  = ~(8'h01 << digit_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 8'hFF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= ~dp_mask[digit_idx];
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the CPU top's 32-bit `display_data` word: shows it as 8 hex digits on a multiplexed, common-anode 7-segment display.
- Holds the word in a shadow register, written only when `load` is pulsed, so the display stays stable while the CPU keeps running.
- A refresh divider steps through the digits; every digit is decoded to active-low segment patterns.
- Sits between the MIPS top and the board pins, in the same clock domain as the CPU.

Parameters:
- CLK_DIV, 50000: clock cycles each digit stays lit; legal range 2..2^20.
- DIGITS, 8: number of digits scanned; legal range 1..8. Digit k shows data_in[4k+3:4k].
- LZS, 0: 1 enables leading-zero suppression.

Ports:
- clk  in  1  system clock, same as the CPU.
- rst  in  1  synchronous reset, active-high.
- data_in  in  32  word to display (`display_data`).
- load  in  1  on a clock edge with load=1, the shadow register captures data_in.
- blank_mask  in  8  bit k=1 forces digit k dark; sampled live, not shadowed.
- dp_mask  in  8  bit k=1 lights the decimal point of digit k.
- an  out  8  digit enables, active-low; exactly one bit is 0 when not in reset.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- digit_idx  out  3  index of the digit currently driven (debug).

Behaviour:
- Reset (sampled on a clk edge while rst=1):
  - shadow=0, div_cnt=0, digit_idx=0;
  - an=8'hFF, seg=7'h7F, dp=1.
  - rst overrides load in the same cycle.
  - Reset asserted mid-scan truncates the current digit period immediately.
- Divider: div_cnt counts 0..CLK_DIV-1.
  - At div_cnt==CLK_DIV-1: div_cnt<=0 and digit_idx<=(digit_idx==DIGITS-1)?0:digit_idx+1.
  - Each digit is therefore selected for exactly CLK_DIV cycles; a full frame is DIGITS*CLK_DIV cycles.
- Shadow register:
  - load=1 at edge N → shadow=data_in from cycle N+1.
  - load held high → shadow tracks data_in every cycle.
  - The load path is independent of the divider; loading never resets the scan position.
- Output register: an/seg/dp are registered and computed from (digit_idx, shadow, blank_mask, dp_mask) of the previous cycle, giving one cycle of latency.
  - an: bit digit_idx is 0, all other bits 1. For DIGITS<8, bits DIGITS..7 are always 1.
  - Latency from load to visible: a load at edge N first appears on the pins after edge N+2, provided that digit is selected.
- Hex decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanking:
  - If blank_mask[digit_idx]=1, seg=7'h7F; the an bit still goes low.
  - dp follows ~dp_mask[digit_idx] independently of blanking.
- LZS=1:
  - Digit k>0 is blanked if all shadow nibbles k..DIGITS-1 are zero.
  - Digit 0 is never suppressed, so 32'h0 shows a single "0".
  - Suppression is evaluated on the shadow contents, not on data_in.
- No X on any output after the first reset edge. Behaviour before the first reset is undefined.

Test Plan:
- Reset and scan (CLK_DIV=4, DIGITS=8):
  - Stimulus: rst high 2 cycles, then low.
  - Required: an=FF, seg=7F, dp=1 during reset.
  - Required: after the first post-reset edge, an=FE; an changes every 4 cycles FE→FD→FB→…→7F→FE; digit_idx wraps 7→0.
- Load latency:
  - Stimulus: load 32'h1234ABCD at edge N while digit 0 is selected.
  - Required: seg=0100001 ("d") after edge N+2; later digits show C,b,A,4,3,2,1.
  - Required: shadow unchanged after load drops and data_in changes to 32'hFFFFFFFF.
- All-hex decode:
  - Stimulus: load 32'h76543210, then 32'hFEDCBA98.
  - Required: each of the 16 digit patterns matches the decode table.
- Blank and dp masks:
  - Stimulus: blank_mask=8'h0F, dp_mask=8'h81.
  - Required: digits 0–3 show seg=7F with their an bit still low; dp=0 only on digits 0 and 7.
- LZS=1:
  - Stimulus: load 32'h00000A00.
  - Required: digits 3–7 blanked; digits 2,1,0 show A,0,0.
  - Stimulus: load 32'h0.
  - Required: only digit 0 shows "0".
- Reset mid-scan and rst vs load priority:
  - Stimulus: rst high at digit 5 with div_cnt=2, and load=1 in the same cycle.
  - Required: shadow=0, an=FF, seg=7F, dp=1 during reset; scan restarts at an=FE with the full 4-cycle period.
